uart_rx_ctrl: RTL and testbench
===============================

UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 Parameter DATA_BITS, default 8, number of data bits per frame (5..8), LSB first.
REQ-002 Parameter OVERSAMPLE, default 16, baud_tick pulses per bit period (even, >=4).
REQ-003 Port clock  input  1  single system clock; all logic rising-edge.
REQ-004 Port reset  input  1  synchronous, active-high reset.
REQ-005 Port baud_tick  input  1  one-clock pulse at OVERSAMPLE x baud rate, from the RX baud generator.
REQ-006 Port rx  input  1  asynchronous serial line, idle high.
REQ-007 Port rx_data  output  DATA_BITS  last accepted frame payload.
REQ-008 Port rx_valid  output  1  rx_data holds an unconsumed frame.
REQ-009 Port rx_ready  input  1  consumer accepts rx_data when rx_valid && rx_ready at a clock edge.
REQ-010 Port frame_err  output  1  one-clock pulse: stop bit sampled low.
REQ-011 Port overrun_err  output  1  one-clock pulse: completed frame dropped, holding register full.
REQ-012 Port busy  output  1  high whenever state != IDLE.

Function
REQ-013 rx SHALL pass a 2-flop synchronizer; the FSM SHALL use only the synchronized value rx_s (2-clock latency).
REQ-014 FSM states IDLE, START, DATA, STOP; tick_cnt (clog2(OVERSAMPLE) bits) and bit_cnt advance only on cycles with baud_tick=1.
REQ-015 IDLE: on baud_tick with rx_s=0 -> START, tick_cnt=0.
REQ-016 START: on the tick where tick_cnt==OVERSAMPLE/2-1, sample rx_s; 1 -> IDLE (glitch rejected, no error); 0 -> DATA, tick_cnt=0, bit_cnt=0.
REQ-017 DATA: on tick where tick_cnt==OVERSAMPLE-1, shift rx_s into shift register MSB, LSB-first, bit_cnt++ and tick_cnt wraps to 0; after bit DATA_BITS-1 -> STOP.
REQ-018 STOP: on tick where tick_cnt==OVERSAMPLE-1, sample rx_s and return to IDLE in the same edge.
REQ-019 Stop=1: frame complete; stop=0: frame_err=1 for the following clock, payload discarded, rx_valid unchanged.
REQ-020 Frame complete with rx_valid=0: rx_data loaded, rx_valid=1 on the next clock (1-clock latency from stop-sample edge).
REQ-021 rx_valid SHALL stay high and rx_data stable until a valid&&ready edge, which clears rx_valid.
REQ-022 Frame complete while rx_valid=1 and rx_ready=0: new payload dropped, old rx_data retained, overrun_err pulses 1 clock.
REQ-023 Frame complete in the same edge as valid&&ready: new payload loaded, rx_valid stays 1, no overrun.
REQ-024 Frame error and overrun SHALL never pulse together; frame error takes precedence.
REQ-025 baud_tick held low SHALL freeze the FSM and counters indefinitely without data loss.

Reset
REQ-026 On reset=1 at a clock edge: state IDLE, tick_cnt=0, bit_cnt=0, shift register 0, rx_data=0, rx_valid=0, frame_err=0, overrun_err=0, busy=0, synchronizer flops=1.
REQ-027 Reset mid-frame SHALL abort the frame with no error pulse and no delivery; reset dominates rx_ready and baud_tick.

Structure
REQ-028 Shared package uart_pkg SHALL hold the FSM state encoding (2-bit localparams) and defaults DATA_BITS=8, OVERSAMPLE=16.
REQ-029 One sub-module uart_rx_sync (2-flop synchronizer, reset value 1) SHALL be instantiated; the rest is flat in uart_rx_ctrl.
REQ-030 The baud tick source SHALL be external; uart_rx_ctrl SHALL contain no clock-rate divider.

Verification
REQ-031 Bench drives baud_tick one clock in every 4 (bit = 64 clocks), rx_ready=1; frame 0xA5, stop=1 -> rx_data=0xA5, rx_valid 1 clock after stop sample, no errors.
REQ-032 rx low for 3 ticks then high -> returns to IDLE, busy falls, no rx_valid, no frame_err.
REQ-033 Frame 0x3C with stop=0 -> frame_err single pulse, rx_valid stays 0, then next frame 0x81 received correctly.
REQ-034 rx_ready=0, frames 0x11 then 0x22 -> rx_data=0x11 retained, overrun_err one pulse at second frame end; then ready=1 -> rx_valid clears.
REQ-035 rx_ready pulsed on exact stop-sample edge of frame 0x55 while 0x11 pending -> rx_data=0x55, rx_valid stays 1, overrun_err=0.
REQ-036 reset asserted during bit 4 of frame 0xFF -> all outputs at reset values next edge; subsequent 0x0F received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART receiver definitions: FSM state encoding and default frame geometry.
package uart_pkg;

  localparam int DEF_DATA_BITS  = 8;
  localparam int DEF_OVERSAMPLE = 16;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    START = ST_START,
    DATA  = ST_DATA,
    STOP  = ST_STOP
  } rx_state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous rx line; 2-clock latency, resets to idle-high.
module uart_rx_sync (
  input  logic clock,
  input  logic reset,
  input  logic rx,
  output logic rx_s
);

  logic meta;

  always_ff @(posedge clock) begin
    if (reset) begin
      meta <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      meta <= rx;
      rx_s <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// Oversampling UART receiver with a one-deep holding register; result valid 1 clock after stop sample.
// A frame completing while the holding register is full and not being drained is dropped (overrun).
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = DEF_DATA_BITS,
  parameter int OVERSAMPLE = DEF_OVERSAMPLE
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 baud_tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun_err,
  output logic                 busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [TW-1:0] HALF_TICK = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] FULL_TICK = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);

  logic rx_s;

  uart_rx_sync u_sync (
    .clock (clock),
    .reset (reset),
    .rx    (rx),
    .rx_s  (rx_s)
  );

  rx_state_t            state, state_n;
  logic [TW-1:0]        tick_cnt, tick_n;
  logic [BW-1:0]        bit_cnt, bit_n;
  logic [DATA_BITS-1:0] shift_q, shift_n;
  logic [DATA_BITS-1:0] data_n;
  logic                 valid_n, ferr_n, ovr_n;

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      tick_cnt    <= '0;
      bit_cnt     <= '0;
      shift_q     <= '0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      state       <= state_n;
      tick_cnt    <= tick_n;
      bit_cnt     <= bit_n;
      shift_q     <= shift_n;
      rx_data     <= data_n;
      rx_valid    <= valid_n;
      frame_err   <= ferr_n;
      overrun_err <= ovr_n;
    end
  end

  always_comb begin
    state_n = state;
    tick_n  = tick_cnt;
    bit_n   = bit_cnt;
    shift_n = shift_q;
    data_n  = rx_data;
    valid_n = rx_valid;
    ferr_n  = 1'b0;
    ovr_n   = 1'b0;

    if (rx_valid && rx_ready) valid_n = 1'b0;

    if (baud_tick) begin
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state_n = START;
            tick_n  = '0;
          end
        end
        START: begin
          // Mid-start-bit recheck filters line glitches shorter than half a bit.
          if (tick_cnt == HALF_TICK) begin
            if (rx_s) begin
              state_n = IDLE;
            end else begin
              state_n = DATA;
              tick_n  = '0;
              bit_n   = '0;
            end
          end else begin
            tick_n = tick_cnt + 1'b1;
          end
        end
        DATA: begin
          if (tick_cnt == FULL_TICK) begin
            shift_n = {rx_s, shift_q[DATA_BITS-1:1]};
            tick_n  = '0;
            bit_n   = bit_cnt + 1'b1;
            if (bit_cnt == LAST_BIT) begin
              state_n = STOP;
              bit_n   = '0;
            end
          end else begin
            tick_n = tick_cnt + 1'b1;
          end
        end
        STOP: begin
          if (tick_cnt == FULL_TICK) begin
            state_n = IDLE;
            tick_n  = '0;
            // A framing error discards the payload before overrun is even considered.
            if (!rx_s) begin
              ferr_n = 1'b1;
            end else if (rx_valid && !rx_ready) begin
              ovr_n = 1'b1;
            end else begin
              data_n  = shift_q;
              valid_n = 1'b1;
            end
          end else begin
            tick_n = tick_cnt + 1'b1;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: serial frames built from bit timing, results checked against expected payloads and edges.
module tb_uart_rx_ctrl;

  logic       clock = 1'b0;
  logic       reset;
  logic       baud_tick;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun_err;
  logic       busy;

  always #5 clock = ~clock;

  uart_rx_ctrl #(.DATA_BITS(8), .OVERSAMPLE(16)) dut (
    .clock       (clock),
    .reset       (reset),
    .baud_tick   (baud_tick),
    .rx          (rx),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .frame_err   (frame_err),
    .overrun_err (overrun_err),
    .busy        (busy)
  );

  int checks = 0;
  int errors = 0;

  // cyc numbers clock edges; ph advances only while ticks are enabled.
  int cyc = 0;
  int ph  = 0;
  bit tick_en   = 1'b1;
  bit ready_lvl = 1'b1;
  int ready_pulse_edge = -1;

  logic [7:0] got_q[$];
  int ferr_cnt, ovr_cnt, both_cnt;
  int rise_edge, ferr_edge, ovr_edge;
  logic prev_valid;

  task automatic clear_obs();
    got_q.delete();
    ferr_cnt  = 0;
    ovr_cnt   = 0;
    both_cnt  = 0;
    rise_edge = -1;
    ferr_edge = -1;
    ovr_edge  = -1;
  endtask

  task automatic step();
    @(negedge clock);
    baud_tick = tick_en && (ph % 4 == 0);
    rx_ready  = (cyc == ready_pulse_edge) ? 1'b1 : ready_lvl;
    #1;
    if (!reset && rx_valid && rx_ready) got_q.push_back(rx_data);
    prev_valid = rx_valid;
    @(posedge clock);
    #1;
    if (rx_valid && !prev_valid) rise_edge = cyc;
    if (frame_err) begin ferr_cnt++; ferr_edge = cyc; end
    if (overrun_err) begin ovr_cnt++; ovr_edge = cyc; end
    if (frame_err && overrun_err) both_cnt++;
    if (tick_en) ph++;
    cyc++;
  endtask

  task automatic hold(input logic v, input int n);
    rx = v;
    repeat (n) step();
  endtask

  task automatic freeze(input logic v, input int n);
    tick_en = 1'b0;
    rx = v;
    repeat (n) step();
    tick_en = 1'b1;
  endtask

  // Edge at which the stop bit of a frame starting now is sampled: first tick
  // once the falling edge is through the synchronizer, then half a bit to
  // mid-start, 8 data bits and one stop bit, 64 clocks per bit.
  function automatic int predict_stop();
    int dd = 2;
    while ((ph + dd) % 4 != 0) dd++;
    return cyc + dd + 32 + 8 * 64 + 64;
  endfunction

  task automatic send_frame(input logic [7:0] d, input logic stopb, input int fbit);
    hold(1'b0, 64);
    for (int i = 0; i < 8; i++) begin
      if (i == fbit) begin
        hold(d[i], 32);
        freeze(d[i], 150);
        hold(d[i], 32);
      end else begin
        hold(d[i], 64);
      end
    end
    hold(stopb, 64);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    rx = 1'b1;
    repeat (3) step();
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", rx_valid); end
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_data got %h exp 00", rx_data); end
    checks++; if (frame_err !== 1'b0 || overrun_err !== 1'b0) begin errors++; $display("FAIL reset_errs got %b%b exp 00", frame_err, overrun_err); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    reset = 1'b0;
    hold(1'b1, 20);
  endtask

  task automatic test_basic();
    int s;
    clear_obs();
    ready_lvl = 1'b1;
    s = predict_stop();
    send_frame(8'hA5, 1'b1, -1);
    hold(1'b1, 10);
    checks++; if (got_q.size() != 1 || got_q[0] !== 8'hA5) begin errors++; $display("FAIL basic_data got n=%0d %h exp n=1 a5", got_q.size(), (got_q.size() > 0) ? got_q[0] : 8'hxx); end
    checks++; if (rise_edge != s) begin errors++; $display("FAIL basic_valid_edge got %0d exp %0d", rise_edge, s); end
    checks++; if (ferr_cnt != 0 || ovr_cnt != 0) begin errors++; $display("FAIL basic_errs got ferr=%0d ovr=%0d exp 0 0", ferr_cnt, ovr_cnt); end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL basic_consumed got %b exp 0", rx_valid); end
  endtask

  task automatic test_glitch();
    clear_obs();
    rx = 1'b0;
    repeat (12) step();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL glitch_busy_high got %b exp 1", busy); end
    hold(1'b1, 80);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL glitch_busy_low got %b exp 0", busy); end
    checks++; if (rise_edge != -1 || got_q.size() != 0) begin errors++; $display("FAIL glitch_no_valid got rise=%0d n=%0d exp -1 0", rise_edge, got_q.size()); end
    checks++; if (ferr_cnt != 0) begin errors++; $display("FAIL glitch_no_ferr got %0d exp 0", ferr_cnt); end
  endtask

  task automatic test_frame_err();
    int s;
    clear_obs();
    s = predict_stop();
    send_frame(8'h3C, 1'b0, -1);
    hold(1'b1, 80);
    checks++; if (ferr_cnt != 1) begin errors++; $display("FAIL ferr_count got %0d exp 1", ferr_cnt); end
    checks++; if (ferr_edge != s) begin errors++; $display("FAIL ferr_edge got %0d exp %0d", ferr_edge, s); end
    checks++; if (rise_edge != -1 || rx_valid !== 1'b0) begin errors++; $display("FAIL ferr_no_valid got rise=%0d valid=%b exp -1 0", rise_edge, rx_valid); end
    checks++; if (ovr_cnt != 0) begin errors++; $display("FAIL ferr_no_ovr got %0d exp 0", ovr_cnt); end
    clear_obs();
    send_frame(8'h81, 1'b1, -1);
    hold(1'b1, 10);
    checks++; if (got_q.size() != 1 || got_q[0] !== 8'h81) begin errors++; $display("FAIL ferr_recover got n=%0d %h exp n=1 81", got_q.size(), (got_q.size() > 0) ? got_q[0] : 8'hxx); end
    checks++; if (ferr_cnt != 0) begin errors++; $display("FAIL ferr_recover_errs got %0d exp 0", ferr_cnt); end
  endtask

  task automatic test_overrun();
    int s2;
    clear_obs();
    ready_lvl = 1'b0;
    send_frame(8'h11, 1'b1, -1);
    hold(1'b1, 10);
    s2 = predict_stop();
    send_frame(8'h22, 1'b1, -1);
    hold(1'b1, 10);
    checks++; if (ovr_cnt != 1) begin errors++; $display("FAIL ovr_count got %0d exp 1", ovr_cnt); end
    checks++; if (ovr_edge != s2) begin errors++; $display("FAIL ovr_edge got %0d exp %0d", ovr_edge, s2); end
    checks++; if (rx_data !== 8'h11 || rx_valid !== 1'b1) begin errors++; $display("FAIL ovr_retain got %h v=%b exp 11 v=1", rx_data, rx_valid); end
    checks++; if (ferr_cnt != 0 || both_cnt != 0) begin errors++; $display("FAIL ovr_no_ferr got %0d %0d exp 0 0", ferr_cnt, both_cnt); end
    ready_lvl = 1'b1;
    hold(1'b1, 3);
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL ovr_drain_valid got %b exp 0", rx_valid); end
    checks++; if (got_q.size() != 1 || got_q[0] !== 8'h11) begin errors++; $display("FAIL ovr_drain_data got n=%0d %h exp n=1 11", got_q.size(), (got_q.size() > 0) ? got_q[0] : 8'hxx); end
  endtask

  task automatic test_ready_on_stop();
    int s;
    clear_obs();
    ready_lvl = 1'b0;
    send_frame(8'h11, 1'b1, -1);
    hold(1'b1, 10);
    s = predict_stop();
    ready_pulse_edge = s;
    send_frame(8'h55, 1'b1, -1);
    hold(1'b1, 5);
    ready_pulse_edge = -1;
    checks++; if (rx_data !== 8'h55 || rx_valid !== 1'b1) begin errors++; $display("FAIL same_edge_load got %h v=%b exp 55 v=1", rx_data, rx_valid); end
    checks++; if (ovr_cnt != 0) begin errors++; $display("FAIL same_edge_no_ovr got %0d exp 0", ovr_cnt); end
    checks++; if (got_q.size() != 1 || got_q[0] !== 8'h11) begin errors++; $display("FAIL same_edge_old got n=%0d %h exp n=1 11", got_q.size(), (got_q.size() > 0) ? got_q[0] : 8'hxx); end
    ready_lvl = 1'b1;
    hold(1'b1, 3);
    checks++; if (got_q.size() != 2 || got_q[1] !== 8'h55 || rx_valid !== 1'b0) begin errors++; $display("FAIL same_edge_new got n=%0d v=%b exp n=2 55 v=0", got_q.size(), rx_valid); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] d;
    d = 8'($urandom_range(0, 255));
    clear_obs();
    ready_lvl = 1'b0;
    send_frame(d, 1'b1, -1);
    hold(1'b1, 10);
    hold(1'b0, 64);
    for (int i = 0; i < 4; i++) hold(1'b1, 64);
    hold(1'b1, 30);
    reset = 1'b1;
    ready_lvl = 1'b1;
    step();
    checks++; if (rx_valid !== 1'b0 || rx_data !== 8'h00) begin errors++; $display("FAIL midrst_out got %h v=%b exp 00 v=0", rx_data, rx_valid); end
    checks++; if (busy !== 1'b0 || frame_err !== 1'b0 || overrun_err !== 1'b0) begin errors++; $display("FAIL midrst_flags got b=%b f=%b o=%b exp 000", busy, frame_err, overrun_err); end
    reset = 1'b0;
    clear_obs();
    hold(1'b1, 34 + 4 * 64 + 20);
    checks++; if (got_q.size() != 0 || ferr_cnt != 0 || ovr_cnt != 0) begin errors++; $display("FAIL midrst_abort got n=%0d f=%0d o=%0d exp 0 0 0", got_q.size(), ferr_cnt, ovr_cnt); end
    send_frame(8'h0F, 1'b1, -1);
    hold(1'b1, 10);
    checks++; if (got_q.size() != 1 || got_q[0] !== 8'h0F) begin errors++; $display("FAIL midrst_next got n=%0d %h exp n=1 0f", got_q.size(), (got_q.size() > 0) ? got_q[0] : 8'hxx); end
  endtask

  task automatic test_freeze();
    logic [7:0] d;
    d = 8'($urandom_range(0, 255));
    clear_obs();
    send_frame(d, 1'b1, 3);
    hold(1'b1, 10);
    checks++; if (got_q.size() != 1 || got_q[0] !== d) begin errors++; $display("FAIL freeze_data got n=%0d %h exp n=1 %h", got_q.size(), (got_q.size() > 0) ? got_q[0] : 8'hxx, d); end
    checks++; if (ferr_cnt != 0) begin errors++; $display("FAIL freeze_errs got %0d exp 0", ferr_cnt); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_q[$];
    logic [7:0] d;
    logic       sb;
    int         nfe = 0;
    clear_obs();
    ready_lvl = 1'b1;
    for (int k = 0; k < 8; k++) begin
      d  = 8'($urandom_range(0, 255));
      sb = ($urandom_range(0, 4) != 0);
      send_frame(d, sb, -1);
      if (sb) exp_q.push_back(d);
      else nfe++;
      hold(1'b1, sb ? $urandom_range(0, 30) : 70 + $urandom_range(0, 30));
    end
    hold(1'b1, 10);
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL b2b_count got %0d exp %0d", got_q.size(), exp_q.size()); end
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
      checks++; if (got_q[k] !== exp_q[k]) begin errors++; $display("FAIL b2b_data[%0d] got %h exp %h", k, got_q[k], exp_q[k]); end
    end
    checks++; if (ferr_cnt != nfe) begin errors++; $display("FAIL b2b_ferr got %0d exp %0d", ferr_cnt, nfe); end
    checks++; if (ovr_cnt != 0 || both_cnt != 0) begin errors++; $display("FAIL b2b_ovr got %0d %0d exp 0 0", ovr_cnt, both_cnt); end
  endtask

  initial begin
    reset     = 1'b1;
    rx        = 1'b1;
    baud_tick = 1'b0;
    rx_ready  = 1'b1;
    clear_obs();
    test_reset();
    test_basic();
    test_glitch();
    test_frame_err();
    test_overrun();
    test_ready_on_stop();
    test_reset_mid();
    test_freeze();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
